// File: rtl/reg_wb_scoreboard_pkg.sv
// Shared constants and types for the register write-back scoreboard.
// Imported by the arbiter and the scoreboard top.
package reg_wb_scoreboard_pkg;

    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 32;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LDR = 1'b1
    } wb_req_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter for the register bank write port.
// The tie pointer moves only when both requesters collide.
module wb_rr_arb2
    import reg_wb_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_ldr,
    output logic gnt_alu,
    output logic gnt_ldr
);

    wb_req_e ptr_q;
    wb_req_e ptr_d;

    // Grant a lone requester; on a tie grant the favoured side and flip.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_ldr = 1'b0;
        ptr_d   = ptr_q;
        if (req_alu && req_ldr) begin
            if (ptr_q == WB_ALU) begin
                gnt_alu = 1'b1;
                ptr_d   = WB_LDR;
            end else begin
                gnt_ldr = 1'b1;
                ptr_d   = WB_ALU;
            end
        end else begin
            gnt_alu = req_alu;
            gnt_ldr = req_ldr;
        end
    end

    // Tie pointer register; after reset the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= WB_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reg_wb_scoreboard.sv
// Register bank controller: busy scoreboard, issue hazard gate,
// write-port arbitration and a registered write to the bank.
module reg_wb_scoreboard
    import reg_wb_scoreboard_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dest,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_src1,
    input  logic          issue_use1,
    input  logic [AW-1:0] issue_src2,
    input  logic          issue_use2,
    output logic          issue_ready,
    input  logic          alu_wb_valid,
    input  logic [AW-1:0] alu_wb_dest,
    input  logic [DW-1:0] alu_wb_data,
    output logic          alu_wb_ready,
    input  logic          ldr_wb_valid,
    input  logic [AW-1:0] ldr_wb_dest,
    input  logic [DW-1:0] ldr_wb_data,
    output logic          ldr_wb_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW:0]   pending_cnt,
    output logic          err_unexpected_wb
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            gnt_alu, gnt_ldr, wb_gnt, wb_ok;
    logic            issue_set;
    logic [AW-1:0]   wb_dest;
    logic [DW-1:0]   wb_data;

    wb_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (alu_wb_valid),
        .req_ldr (ldr_wb_valid),
        .gnt_alu (gnt_alu),
        .gnt_ldr (gnt_ldr)
    );

    // Hazard gate, grant mux and next-state for scoreboard and write port.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_use1 && busy_q[issue_src1]) issue_ready = 1'b0;
        if (issue_use2 && busy_q[issue_src2]) issue_ready = 1'b0;
        if (issue_wr && busy_q[issue_dest])   issue_ready = 1'b0;
        issue_set = issue_valid && issue_ready && issue_wr;

        wb_gnt  = gnt_alu || gnt_ldr;
        wb_dest = gnt_alu ? alu_wb_dest : ldr_wb_dest;
        wb_data = gnt_alu ? alu_wb_data : ldr_wb_data;
        wb_ok   = wb_gnt && busy_q[wb_dest];

        // The committing register clears before the new issue sets;
        // they never collide because the issue is blocked by busy.
        busy_d = busy_q;
        if (rf_we_q)   busy_d[rf_waddr_q] = 1'b0;
        if (issue_set) busy_d[issue_dest] = 1'b1;

        rf_we_d    = wb_ok;
        rf_waddr_d = wb_ok ? wb_dest : rf_waddr_q;
        rf_wdata_d = wb_ok ? wb_data : rf_wdata_q;

        err_d = err_q || (wb_gnt && !busy_q[wb_dest]);

        cnt_d = cnt_q;
        if (issue_set && !rf_we_q && cnt_q != (AW+1)'(NREG)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!issue_set && rf_we_q && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers; reset drops any grant still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign alu_wb_ready      = gnt_alu;
    assign ldr_wb_ready      = gnt_ldr;
    assign rf_we             = rf_we_q;
    assign rf_waddr          = rf_waddr_q;
    assign rf_wdata          = rf_wdata_q;
    assign pending_cnt       = cnt_q;
    assign err_unexpected_wb = err_q;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed bench for reg_wb_scoreboard with hand-computed expectations.
// Inputs change 1 time unit after the rising edge.
module tb_reg_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_wr, issue_use1, issue_use2;
    logic [3:0]  issue_dest, issue_src1, issue_src2;
    logic        issue_ready;
    logic        alu_wb_valid, ldr_wb_valid;
    logic [3:0]  alu_wb_dest, ldr_wb_dest;
    logic [31:0] alu_wb_data, ldr_wb_data;
    logic        alu_wb_ready, ldr_wb_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  pending_cnt;
    logic        err_unexpected_wb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_scoreboard dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .issue_valid       (issue_valid),
        .issue_dest        (issue_dest),
        .issue_wr          (issue_wr),
        .issue_src1        (issue_src1),
        .issue_use1        (issue_use1),
        .issue_src2        (issue_src2),
        .issue_use2        (issue_use2),
        .issue_ready       (issue_ready),
        .alu_wb_valid      (alu_wb_valid),
        .alu_wb_dest       (alu_wb_dest),
        .alu_wb_data       (alu_wb_data),
        .alu_wb_ready      (alu_wb_ready),
        .ldr_wb_valid      (ldr_wb_valid),
        .ldr_wb_dest       (ldr_wb_dest),
        .ldr_wb_data       (ldr_wb_data),
        .ldr_wb_ready      (ldr_wb_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .pending_cnt       (pending_cnt),
        .err_unexpected_wb (err_unexpected_wb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        issue_valid  = 0; issue_wr = 0; issue_dest = 0;
        issue_use1   = 0; issue_src1 = 0;
        issue_use2   = 0; issue_src2 = 0;
        alu_wb_valid = 0; alu_wb_dest = 0; alu_wb_data = 0;
        ldr_wb_valid = 0; ldr_wb_dest = 0; ldr_wb_data = 0;
    endtask

    task automatic do_issue(input logic [3:0] d);
        issue_valid = 1; issue_wr = 1; issue_dest = d;
        tick();
        issue_valid = 0; issue_wr = 0; issue_dest = 0;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 0;
        #3;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++; $display("FAIL rst_we got %0h exp 0", rf_we);
        end
        checks++;
        if (rf_waddr !== 4'd0 || rf_wdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_wport got %0h/%0h exp 0/0", rf_waddr, rf_wdata);
        end
        checks++;
        if (pending_cnt !== 5'd0 || err_unexpected_wb !== 1'b0) begin
            errors++;
            $display("FAIL rst_cnt_err got %0d/%0h exp 0/0",
                     pending_cnt, err_unexpected_wb);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_issue();
        issue_valid = 1; issue_wr = 1; issue_dest = 3;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL issue_rdy got %0h exp 1", issue_ready);
        end
        tick();
        clr_inputs();
        checks++;
        if (pending_cnt !== 5'd1) begin
            errors++; $display("FAIL issue_cnt got %0d exp 1", pending_cnt);
        end
        issue_use1 = 1; issue_src1 = 3;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL raw_block got %0h exp 0", issue_ready);
        end
        clr_inputs();
        issue_wr = 1; issue_dest = 3;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL waw_block got %0h exp 0", issue_ready);
        end
        clr_inputs();
    endtask

    task automatic test_alu_wb();
        alu_wb_valid = 1; alu_wb_dest = 3; alu_wb_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || ldr_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_gnt got %0h/%0h exp 1/0",
                     alu_wb_ready, ldr_wb_ready);
        end
        tick();
        clr_inputs();
        issue_use1 = 1; issue_src1 = 3;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd3 ||
            rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_commit got %0h/%0h/%0h exp 1/3/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL no_bypass got %0h exp 0", issue_ready);
        end
        tick();
        checks++;
        if (issue_ready !== 1'b1 || pending_cnt !== 5'd0) begin
            errors++;
            $display("FAIL alu_clear got %0h/%0d exp 1/0",
                     issue_ready, pending_cnt);
        end
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 4'd3) begin
            errors++;
            $display("FAIL we_drop got %0h/%0h exp 0/3", rf_we, rf_waddr);
        end
        clr_inputs();
    endtask

    task automatic test_back_to_back();
        do_issue(5);
        do_issue(6);
        alu_wb_valid = 1; alu_wb_dest = 5; alu_wb_data = 32'h5555_0005;
        ldr_wb_valid = 1; ldr_wb_dest = 6; ldr_wb_data = 32'h6666_0006;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || ldr_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie1_gnt got %0h/%0h exp 1/0",
                     alu_wb_ready, ldr_wb_ready);
        end
        tick();
        alu_wb_valid = 0;
        #1;
        checks++;
        if (ldr_wb_ready !== 1'b1 || rf_we !== 1'b1 ||
            rf_waddr !== 4'd5 || rf_wdata !== 32'h5555_0005) begin
            errors++;
            $display("FAIL tie1_c1 got %0h/%0h/%0h/%0h exp 1/1/5/55550005",
                     ldr_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        ldr_wb_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd6 ||
            rf_wdata !== 32'h6666_0006) begin
            errors++;
            $display("FAIL tie1_c2 got %0h/%0h/%0h exp 1/6/66660006",
                     rf_we, rf_waddr, rf_wdata);
        end
        tick();
        do_issue(7);
        do_issue(8);
        alu_wb_valid = 1; alu_wb_dest = 7; alu_wb_data = 32'h7777_0007;
        ldr_wb_valid = 1; ldr_wb_dest = 8; ldr_wb_data = 32'h8888_0008;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b0 || ldr_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL tie2_gnt got %0h/%0h exp 0/1",
                     alu_wb_ready, ldr_wb_ready);
        end
        tick();
        ldr_wb_valid = 0;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || rf_we !== 1'b1 ||
            rf_waddr !== 4'd8 || rf_wdata !== 32'h8888_0008) begin
            errors++;
            $display("FAIL tie2_c1 got %0h/%0h/%0h/%0h exp 1/1/8/88880008",
                     alu_wb_ready, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        alu_wb_valid = 0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd7 ||
            rf_wdata !== 32'h7777_0007) begin
            errors++;
            $display("FAIL tie2_c2 got %0h/%0h/%0h exp 1/7/77770007",
                     rf_we, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || pending_cnt !== 5'd0) begin
            errors++;
            $display("FAIL tie_end got %0h/%0d exp 0/0", rf_we, pending_cnt);
        end
        clr_inputs();
    endtask

    task automatic test_unexpected();
        ldr_wb_valid = 1; ldr_wb_dest = 9; ldr_wb_data = 32'h9999_9999;
        #1;
        checks++;
        if (ldr_wb_ready !== 1'b1) begin
            errors++; $display("FAIL unexp_gnt got %0h exp 1", ldr_wb_ready);
        end
        tick();
        clr_inputs();
        checks++;
        if (rf_we !== 1'b0 || err_unexpected_wb !== 1'b1) begin
            errors++;
            $display("FAIL unexp_wb got %0h/%0h exp 0/1",
                     rf_we, err_unexpected_wb);
        end
        checks++;
        if (rf_waddr !== 4'd7 || rf_wdata !== 32'h7777_0007) begin
            errors++;
            $display("FAIL unexp_hold got %0h/%0h exp 7/77770007",
                     rf_waddr, rf_wdata);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (err_unexpected_wb !== 1'b1 || pending_cnt !== 5'd0) begin
            errors++;
            $display("FAIL err_sticky got %0h/%0d exp 1/0",
                     err_unexpected_wb, pending_cnt);
        end
    endtask

    task automatic test_simul_set_clear();
        do_issue(2);
        alu_wb_valid = 1; alu_wb_dest = 2; alu_wb_data = 32'h2222_2222;
        tick();
        clr_inputs();
        issue_valid = 1; issue_wr = 1; issue_dest = 4;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || rf_we !== 1'b1 || pending_cnt !== 5'd1) begin
            errors++;
            $display("FAIL simul_pre got %0h/%0h/%0d exp 1/1/1",
                     issue_ready, rf_we, pending_cnt);
        end
        tick();
        clr_inputs();
        checks++;
        if (pending_cnt !== 5'd1) begin
            errors++; $display("FAIL simul_cnt got %0d exp 1", pending_cnt);
        end
        issue_use1 = 1; issue_src1 = 4;
        issue_use2 = 1; issue_src2 = 4;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL simul_b4 got %0h exp 0", issue_ready);
        end
        issue_src1 = 2; issue_src2 = 2;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL simul_b2 got %0h exp 1", issue_ready);
        end
        clr_inputs();
    endtask

    task automatic test_reset_inflight();
        do_issue(10);
        alu_wb_valid = 1; alu_wb_dest = 10; alu_wb_data = 32'hAAAA_000A;
        tick();
        clr_inputs();
        rst_n = 0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || pending_cnt !== 5'd0 ||
            err_unexpected_wb !== 1'b0) begin
            errors++;
            $display("FAIL rst_fly got %0h/%0d/%0h exp 0/0/0",
                     rf_we, pending_cnt, err_unexpected_wb);
        end
        issue_use1 = 1; issue_src1 = 10;
        issue_use2 = 1; issue_src2 = 4;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL rst_busy got %0h exp 1", issue_ready);
        end
        clr_inputs();
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++; $display("FAIL rst_nowr got %0h exp 0", rf_we);
            end
        end
        alu_wb_valid = 1; ldr_wb_valid = 1;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || ldr_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ptr got %0h/%0h exp 1/0",
                     alu_wb_ready, ldr_wb_ready);
        end
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_issue();
        test_alu_wb();
        test_back_to_back();
        test_unexpected();
        test_simul_set_clear();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_scoreboard.md
Name: reg_wb_scoreboard

Overview:
- Controller for the 16x32 register bank.
- Scoreboards pending destination writes and gates instruction issue on RAW/WAW hazards against source/destination register numbers.
- Arbitrates the bank's single write port between the ALU result path and the LDR (load) result path.
- Drives a registered write-enable/address/data to the bank.

Parameters:
- NREG, 16, number of architectural registers
- AW, 4, register-number width (log2 NREG)
- DW, 32, register data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decoder presents an instruction
- issue_dest  in  AW  destination register number
- issue_wr  in  1  instruction writes issue_dest
- issue_src1  in  AW  source 1 register number
- issue_use1  in  1  instruction reads source 1
- issue_src2  in  AW  source 2 register number
- issue_use2  in  1  instruction reads source 2
- issue_ready  out  1  no hazard; instruction accepted when issue_valid && issue_ready
- alu_wb_valid  in  1  ALU result available
- alu_wb_dest  in  AW  ALU result register
- alu_wb_data  in  DW  ALU result
- alu_wb_ready  out  1  ALU result granted this cycle
- ldr_wb_valid  in  1  load result available
- ldr_wb_dest  in  AW  load result register
- ldr_wb_data  in  DW  load data
- ldr_wb_ready  out  1  load result granted this cycle
- rf_we  out  1  register bank write enable
- rf_waddr  out  AW  register bank write address
- rf_wdata  out  DW  register bank write data
- pending_cnt  out  AW+1  number of busy registers
- err_unexpected_wb  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): busy[NREG-1:0]=0, rf_we=0, rf_waddr=0, rf_wdata=0, pending_cnt=0, err_unexpected_wb=0, round-robin pointer favours ALU. An in-flight grant is dropped.
- issue_ready (combinational, from registered busy only):
  - Low if issue_use1 && busy[issue_src1].
  - Low if issue_use2 && busy[issue_src2].
  - Low if issue_wr && busy[issue_dest].
  - High otherwise, independent of issue_valid.
- Accepted issue with issue_wr sets busy[issue_dest] at the clock edge.
- Arbitration, combinational in cycle N:
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester not granted on the most recent tie. The pointer updates only on ties. First tie after reset goes to ALU.
  - Grant is *_ready=1. Data is consumed at edge N.
- Write-back commit:
  - A grant in cycle N produces rf_we=1 with registered waddr/wdata in cycle N+1. The bank captures at the end of N+1.
  - busy[dest] clears at the end of N+1 and is visible in cycle N+2. No bypass: a dependent instruction issues no earlier than N+2.
  - rf_we=0 in any cycle not preceded by a grant. rf_waddr/rf_wdata hold their last values.
- Unexpected write-back: a granted dest whose busy bit is 0 at grant time is still consumed (ready=1). Its write is suppressed (rf_we stays 0 in N+1), and err_unexpected_wb sets and stays set until reset.
- Simultaneous issue-set and write-back-clear:
  - Same register: cannot occur, because the issue is blocked by busy.
  - Different registers: both take effect.
- pending_cnt:
  - +1 on accepted issue with issue_wr.
  - −1 on committing rf_we.
  - Both in the same cycle: unchanged.
  - Maximum NREG; never wraps.
- Throughput: one write-back commit per cycle; one issue per cycle.

Decomposition:
- Shared package: AW, DW, NREG constants; requester-id enum (WB_ALU=0, WB_LDR=1).
- One natural sub-module, wb_rr_arb2: a two-requester round-robin arbiter with tie pointer.
- The scoreboard, write-port register and counter stay in the top.

Test Plan:
- Reset then issue dest=3 (wr=1, use1/use2=0) -> issue_ready=1; busy[3]=1; pending_cnt=1. Next issue reading src1=3 -> issue_ready=0.
- ALU wb dest=3 data=0xDEADBEEF granted in cycle N -> cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF. Cycle N+2: src1=3 issue_ready=1, pending_cnt=0.
- Busy regs 5 and 6; ALU(5) and LDR(6) valid together -> ALU granted first, LDR next cycle. Second tie (regs 7, 8) -> LDR granted first. rf_we high two consecutive cycles each time.
- LDR wb dest=9 with busy[9]=0 -> ldr_wb_ready=1, rf_we stays 0, err_unexpected_wb=1 and persists across 10 idle cycles.
- Issue dest=4 accepted in the same cycle an earlier wb to reg 2 commits -> pending_cnt unchanged; busy[4]=1, busy[2]=0.
- rst_n low in cycle N+1 while a grant is in flight -> rf_we=0 immediately; busy all 0; pending_cnt=0; no write after reset release.
